timer_dev: RTL and testbench
============================

// Module: timer_dev
// PURPOSE
//   Memory-mapped countdown timer that answers CPU load/store accesses on the data-memory-side bus.
//   It takes the same word address, write enable, write data and 4-bit byte enables that the pipeline drives into dm.
//   It returns read data and raises an interrupt request when the count expires.
//   It sits beside dm_8k behind the MEM-stage address decode.
// PARAMETERS
//   DW      32   data/register width (fixed 32 for the MIPS bus)
//   PRESET0 0    reset value of the PRESET register
// PORTS
//   clk    in   1    system clock, rising-edge
//   rst    in   1    asynchronous, active-high reset
//   A      in   2    word address within the device (byte addr[3:2])
//   We     in   1    store strobe for this device (already qualified by decode)
//   BE     in   4    byte enables, BE[i] covers WD[8i+7:8i]
//   WD     in   32   store data
//   RD     out  32   load data, combinational from A
//   IRQ    out  1    interrupt request, registered
// BEHAVIOUR
//   Registers:
//     A=0 CTRL    [0]=EN, [2:1]=MODE, [3]=IM (irq mask), [31:4] read 0
//     A=1 PRESET  full 32-bit
//     A=2 COUNT   read-only; stores to it are ignored
//     A=3         reads 0, writes ignored
//   Reset values:
//     CTRL=0, PRESET=PRESET0, COUNT=0, state=IDLE, irq_q=0
//     RD reflects reset register contents; IRQ=0.
//   Writes:
//     Applied at posedge when We=1.
//     Per-byte merge: new[8i+7:8i] = BE[i] ? WD : old.
//     BE=0000 with We=1 changes nothing.
//   Reads:
//     RD = reg[A], zero-extended CTRL, no latency.
//   FSM (encoding in pkg):
//     IDLE  EN=1 -> LOAD; else stay, COUNT held.
//     LOAD  COUNT<=PRESET; ->CNT (->IDLE if EN=0).
//     CNT   EN=0 -> IDLE, COUNT frozen.
//           COUNT==0 -> INT, set irq_q.
//           else COUNT<=COUNT-1.
//     INT   MODE=00: EN<=0, ->IDLE; irq_q stays set (sticky) until the next store to CTRL.
//           MODE=01: ->LOAD; irq_q cleared this cycle (1-cycle pulse).
//           MODE=1x: reserved, behaves as 00.
//   IRQ = irq_q & IM.
//   Latency: the store setting EN at edge t0 leads to the IRQ rising edge at t0+PRESET+3.
//   Auto-reload period is PRESET+3 cycles.
//   Boundaries:
//     PRESET=0: INT is reached 3 edges after enable.
//     COUNT never wraps; decrement only when COUNT!=0.
//     A store to PRESET mid-count takes effect only at the next LOAD.
//     A CPU store to CTRL in the same cycle as the INT-state EN clear: the CPU store wins, and irq_q is cleared.
//     A store of EN=0 then EN=1 while in CNT passes through IDLE->LOAD, so COUNT reloads.
//     rst mid-count: everything returns to reset values immediately; no spurious IRQ.
// STRUCTURE
//   timer_pkg: register offsets (CTRL/PRESET/COUNT), CTRL bit indices, MODE codes, FSM state encodings.
//   Sub-module be_merge (old, WD, BE -> merged word): shared with future MMIO devices, instantiated per writable register.
//   The rest (FSM, COUNT datapath, irq_q) stays in timer_dev.
// TESTING
//   1 Reset: assert rst mid-cycle.
//     Required: RD@A0/1/2 = 0/PRESET0/0 and IRQ=0 asynchronously.
//   2 One-shot: PRESET=3, CTRL=0x9 at t0.
//     Required: COUNT reads 3,2,1,0 at t2..t5; IRQ=1 from t6 and held.
//     Required: CTRL reads 0x8 (EN cleared).
//     A store CTRL=0x0 then drops IRQ on the next edge.
//   3 Auto-reload: PRESET=2, CTRL=0xB.
//     Required: IRQ is a 1-cycle pulse every 5 cycles over 4 periods.
//     Required: COUNT reloads to 2 each period.
//   4 Byte enables: PRESET=0x11223344, then store WD=0xAABBCCDD with BE=0101.
//     Required: PRESET reads 0x11BB33DD.
//     Store to A=2 leaves COUNT unchanged.
//   5 Mask and disable: one-shot with IM=0 gives IRQ=0, with irq_q internally set.
//     Then a store with IM=1 (EN=0) clears irq_q, so IRQ stays 0.
//     EN=0 mid-count freezes COUNT at its current value.
//   6 Collision: a store to CTRL in the INT cycle of mode 00.
//     Required: the stored value appears in CTRL and IRQ=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register map,
// CTRL field positions, MODE codes and FSM state encoding.
package timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_W       = 4;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

endpackage

// File: rtl/be_merge.sv
// Byte-enable write merge for MMIO registers: each enabled byte lane takes
// the store data, every other lane keeps the old register contents.
module be_merge #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   old_word,
    input  logic [DW-1:0]   wd,
    input  logic [DW/8-1:0] be,
    output logic [DW-1:0]   merged
);

    for (genvar i = 0; i < DW / 8; i++) begin : g_lane
        assign merged[8*i +: 8] = be[i] ? wd[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule

// File: rtl/timer_dev.sv
// Countdown timer on the data-memory bus: CTRL/PRESET/COUNT registers,
// IDLE->LOAD->CNT->INT sequencer and a maskable interrupt request.
module timer_dev
    import timer_pkg::*;
#(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] PRESET0 = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      A,
    input  logic            We,
    input  logic [DW/8-1:0] BE,
    input  logic [DW-1:0]   WD,
    output logic [DW-1:0]   RD,
    output logic            IRQ
);

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0]     preset_q;
    logic [DW-1:0]     count_q, count_d;
    logic [DW-1:0]     ctrl_word, ctrl_merged, preset_merged;
    timer_state_e      state_q, state_d;
    logic              irq_q, irq_d;
    logic              en_clr;
    logic              ctrl_store, preset_store;
    logic              en;
    logic [1:0]        mode;

    assign ctrl_word    = {{(DW-CTRL_W){1'b0}}, ctrl_q};
    // A byte-less store is a no-op, so it must not count as a CTRL store either.
    assign ctrl_store   = We && (A == ADDR_CTRL) && (BE != '0);
    assign preset_store = We && (A == ADDR_PRESET);
    assign en           = ctrl_q[CTRL_EN];
    assign mode         = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

    be_merge #(.DW(DW)) u_ctrl_merge (
        .old_word (ctrl_word),
        .wd       (WD),
        .be       (BE),
        .merged   (ctrl_merged)
    );

    be_merge #(.DW(DW)) u_preset_merge (
        .old_word (preset_q),
        .wd       (WD),
        .be       (BE),
        .merged   (preset_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= PRESET0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            irq_q   <= irq_d;
            if (preset_store) begin
                preset_q <= preset_merged;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        irq_d   = irq_q;
        en_clr  = 1'b0;
        ctrl_d  = ctrl_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (en) begin
                    count_d = preset_q;
                    state_d = ST_CNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    state_d = ST_INT;
                    irq_d   = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                end
            end
            ST_INT: begin
                // Reserved MODE codes fall into the one-shot branch.
                if (mode == MODE_RELOAD) begin
                    state_d = ST_LOAD;
                    irq_d   = 1'b0;
                end else begin
                    en_clr  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A CPU store to CTRL overrides the hardware EN clear and drops the request.
        if (ctrl_store) begin
            ctrl_d = ctrl_merged[CTRL_W-1:0];
            irq_d  = 1'b0;
        end else if (en_clr) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
    end

    always_comb begin
        RD = '0;
        case (A)
            ADDR_CTRL:   RD = ctrl_word;
            ADDR_PRESET: RD = preset_q;
            ADDR_COUNT:  RD = count_q;
            default:     RD = '0;
        endcase
    end

    assign IRQ = irq_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// Directed and randomized checks of timer_dev against a closed-form timing model
// (phase within the enable timeline decides COUNT, IRQ and EN).
module tb_timer_dev;
    import timer_pkg::*;

    localparam logic [31:0] P0 = 32'h0000_0005;

    logic        clk;
    logic        rst;
    logic [1:0]  A;
    logic        We;
    logic [3:0]  BE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    timer_dev #(.DW(32), .PRESET0(P0)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .We  (We),
        .BE  (BE),
        .WD  (WD),
        .RD  (RD),
        .IRQ (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] a, input logic [3:0] be, input logic [31:0] wd);
        A  = a;
        BE = be;
        WD = wd;
        We = 1'b1;
        tick();
        We = 1'b0;
        BE = 4'h0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        A = a;
        #1;
        check(tag, RD, exp);
    endtask

    // k = rising edges since the edge that stored EN=1.
    function automatic logic [31:0] model_count(int p, bit reload, int k, logic [31:0] prev);
        int j;
        if (k < 2) return prev;
        j = k - 2;
        if (reload) j = j % (p + 3);
        return (j <= p) ? 32'(p - j) : 32'd0;
    endfunction

    function automatic logic model_irq(int p, bit reload, int k);
        int j;
        if (k < 2) return 1'b0;
        j = k - 2;
        if (reload) return (j % (p + 3)) == p + 1;
        return j >= p + 1;
    endfunction

    function automatic logic model_en(int p, bit reload, int k);
        if (reload) return 1'b1;
        return k < p + 4;
    endfunction

    initial begin
        logic [31:0] prev;
        int          pulses;

        rst = 1'b1; We = 1'b0; A = 2'd0; BE = 4'h0; WD = '0;

        // Reset values, sampled before any clock edge.
        #1;
        check("rst_irq", {31'b0, IRQ}, 32'd0);
        check_reg("rst_ctrl", ADDR_CTRL, 32'd0);
        check_reg("rst_preset", ADDR_PRESET, P0);
        check_reg("rst_count", ADDR_COUNT, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // One-shot, PRESET=3, CTRL=EN|IM.
        store(ADDR_PRESET, 4'hF, 32'd3);
        store(ADDR_CTRL, 4'hF, 32'h9);
        tick();
        tick(); check_reg("os_cnt_t2", ADDR_COUNT, 32'd3);
        tick(); check_reg("os_cnt_t3", ADDR_COUNT, 32'd2);
        tick(); check_reg("os_cnt_t4", ADDR_COUNT, 32'd1);
        tick(); check_reg("os_cnt_t5", ADDR_COUNT, 32'd0);
        check("os_irq_t5", {31'b0, IRQ}, 32'd0);
        tick(); check("os_irq_t6", {31'b0, IRQ}, 32'd1);
        tick(); check("os_irq_t7", {31'b0, IRQ}, 32'd1);
        check_reg("os_ctrl_t7", ADDR_CTRL, 32'h8);
        tick(); check("os_irq_t8", {31'b0, IRQ}, 32'd1);
        store(ADDR_CTRL, 4'hF, 32'h0);
        check("os_irq_clr", {31'b0, IRQ}, 32'd0);
        repeat (3) tick();

        // Auto-reload, PRESET=2: one-cycle pulse every 5 edges.
        prev = 32'd0;
        pulses = 0;
        store(ADDR_PRESET, 4'hF, 32'd2);
        store(ADDR_CTRL, 4'hF, 32'hB);
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (IRQ === 1'b1) pulses++;
            check($sformatf("ar_irq_k%0d", k), {31'b0, IRQ}, {31'b0, model_irq(2, 1'b1, k)});
            check_reg($sformatf("ar_cnt_k%0d", k), ADDR_COUNT, model_count(2, 1'b1, k, prev));
        end
        check("ar_pulses", pulses, 32'd4);
        store(ADDR_CTRL, 4'hF, 32'h0);
        prev = model_count(2, 1'b1, 22, prev);
        repeat (3) tick();

        // Byte enables and read-only / unmapped offsets.
        store(ADDR_PRESET, 4'hF, 32'h1122_3344);
        store(ADDR_PRESET, 4'b0101, 32'hAABB_CCDD);
        check_reg("be_preset", ADDR_PRESET, 32'h11BB_33DD);
        store(ADDR_PRESET, 4'b0000, 32'hFFFF_FFFF);
        check_reg("be_zero", ADDR_PRESET, 32'h11BB_33DD);
        store(ADDR_COUNT, 4'hF, 32'hFFFF_FFFF);
        check_reg("count_ro", ADDR_COUNT, prev);
        store(2'd3, 4'hF, 32'hFFFF_FFFF);
        check_reg("addr3_zero", 2'd3, 32'd0);

        // Masked one-shot: request pending internally but IRQ stays low.
        store(ADDR_PRESET, 4'hF, 32'd1);
        store(ADDR_CTRL, 4'hF, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("mask_irq_k%0d", k), {31'b0, IRQ}, 32'd0);
        end
        check("mask_irq_q", {31'b0, dut.irq_q}, 32'd1);
        store(ADDR_CTRL, 4'hF, 32'h8);
        check("unmask_irq", {31'b0, IRQ}, 32'd0);
        check("unmask_irq_q", {31'b0, dut.irq_q}, 32'd0);
        tick();
        check("unmask_irq2", {31'b0, IRQ}, 32'd0);

        // Freeze on EN=0, PRESET change mid-count, reload via IDLE->LOAD.
        store(ADDR_PRESET, 4'hF, 32'd6);
        store(ADDR_CTRL, 4'hF, 32'h1);
        tick();
        tick(); check_reg("frz_cnt_k2", ADDR_COUNT, 32'd6);
        tick(); check_reg("frz_cnt_k3", ADDR_COUNT, 32'd5);
        store(ADDR_PRESET, 4'hF, 32'd9);
        check_reg("frz_cnt_k4", ADDR_COUNT, 32'd4);
        store(ADDR_CTRL, 4'hF, 32'h0);
        check_reg("frz_cnt_k5", ADDR_COUNT, 32'd3);
        store(ADDR_CTRL, 4'hF, 32'h1);
        check_reg("frz_cnt_held", ADDR_COUNT, 32'd3);
        tick(); check_reg("frz_cnt_load", ADDR_COUNT, 32'd3);
        tick(); check_reg("frz_cnt_reload", ADDR_COUNT, 32'd9);
        store(ADDR_CTRL, 4'hF, 32'h0);
        repeat (3) tick();
        check_reg("frz_cnt_stop", ADDR_COUNT, 32'd8);

        // Collision: CPU store to CTRL in the INT cycle of one-shot mode.
        store(ADDR_PRESET, 4'hF, 32'd0);
        store(ADDR_CTRL, 4'hF, 32'h9);
        tick();
        tick();
        tick(); check("col_irq_int", {31'b0, IRQ}, 32'd1);
        store(ADDR_CTRL, 4'hF, 32'h9);
        check_reg("col_ctrl", ADDR_CTRL, 32'h9);
        check("col_irq", {31'b0, IRQ}, 32'd0);
        store(ADDR_CTRL, 4'hF, 32'h0);
        repeat (3) tick();

        // Asynchronous reset with IRQ asserted.
        store(ADDR_PRESET, 4'hF, 32'd2);
        store(ADDR_CTRL, 4'hF, 32'h9);
        repeat (5) tick();
        check("pre_rst_irq", {31'b0, IRQ}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_irq", {31'b0, IRQ}, 32'd0);
        check_reg("arst_ctrl", ADDR_CTRL, 32'd0);
        check_reg("arst_preset", ADDR_PRESET, P0);
        check_reg("arst_count", ADDR_COUNT, 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("post_rst_irq%0d", k), {31'b0, IRQ}, 32'd0);
        end

        // Randomized trials against the timing model.
        prev = 32'd0;
        for (int t = 0; t < 8; t++) begin
            int          p;
            int          n;
            logic [1:0]  mode;
            logic        im;
            bit          rl;
            logic [31:0] ctrlv;
            p     = $urandom_range(0, 6);
            mode  = 2'($urandom_range(0, 3));
            im    = 1'($urandom_range(0, 1));
            rl    = (mode == MODE_RELOAD);
            n     = $urandom_range(p + 4, 3 * p + 13);
            ctrlv = {28'b0, im, mode, 1'b1};
            store(ADDR_PRESET, 4'hF, 32'(p));
            store(ADDR_CTRL, 4'hF, ctrlv);
            for (int k = 1; k <= n; k++) begin
                tick();
                check($sformatf("rnd%0d_irq_k%0d", t, k), {31'b0, IRQ},
                      {31'b0, model_irq(p, rl, k) & im});
                check_reg($sformatf("rnd%0d_cnt_k%0d", t, k), ADDR_COUNT,
                          model_count(p, rl, k, prev));
                check_reg($sformatf("rnd%0d_ctrl_k%0d", t, k), ADDR_CTRL,
                          {28'b0, im, mode, model_en(p, rl, k)});
            end
            store(ADDR_CTRL, 4'hF, 32'h0);
            check($sformatf("rnd%0d_irq_stop", t), {31'b0, IRQ}, 32'd0);
            prev = model_count(p, rl, n + 1, prev);
            repeat (3) tick();
            check_reg($sformatf("rnd%0d_cnt_idle", t), ADDR_COUNT, prev);
            check($sformatf("rnd%0d_irq_idle", t), {31'b0, IRQ}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
